// File: rtl/noc_params_pkg.sv
// noc_params: flit and port types shared by the router input-port blocks.
// Holds the address/payload sizes, flit label and output-port enums, the flit
// layout (head flits carry a destination, body/tail flits a raw payload), the
// input-buffer packet states and two small label decoders.
package noc_params;

   localparam int VC_NUM            = 2;
   localparam int VC_SIZE           = $clog2(VC_NUM);
   localparam int DEST_ADDR_SIZE_X  = 4;
   localparam int DEST_ADDR_SIZE_Y  = 4;
   localparam int HEAD_PAYLOAD_SIZE = 8;
   localparam int FLIT_DATA_SIZE    = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + HEAD_PAYLOAD_SIZE;

   typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

   typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

   typedef struct packed {
      logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
      logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
      logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
   } head_data_t;

   typedef union packed {
      head_data_t                head_data;
      logic [FLIT_DATA_SIZE-1:0] bt_pl;
   } flit_data_t;

   typedef struct packed {
      flit_label_t        flit_label;
      logic [VC_SIZE-1:0] vc_id;
      flit_data_t         data;
   } flit_t;

   typedef enum logic [1:0] {IB_IDLE, IB_VA, IB_ACTIVE} ib_state_t;

   function automatic logic is_head(flit_label_t l);
      return (l == HEAD) || (l == HEADTAIL);
   endfunction

   function automatic logic is_tail(flit_label_t l);
      return (l == TAIL) || (l == HEADTAIL);
   endfunction

endpackage

// File: rtl/noc_input_buffer_circular_buffer.sv
// circular_buffer: flit FIFO with wrapping read/write pointers and occupancy count.
// Ports: clk, rst (async, active-low); data_i/write_i push request; read_i pop request;
// vc_i replaces vc_id of the popped flit; data_o registered popped flit (held between
// pops); head_label_o label at the read pointer; wr_acc_o/rd_acc_o accepted strobes;
// is_full_o/is_empty_o/count_o occupancy.
module circular_buffer
   import noc_params::*;
#(
   parameter int BUFFER_SIZE = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  flit_t                        data_i,
   input  logic                         write_i,
   input  logic                         read_i,
   input  logic [VC_SIZE-1:0]           vc_i,
   output flit_t                        data_o,
   output flit_label_t                  head_label_o,
   output logic                         wr_acc_o,
   output logic                         rd_acc_o,
   output logic                         is_full_o,
   output logic                         is_empty_o,
   output logic [$clog2(BUFFER_SIZE):0] count_o
);

   localparam int PW = $clog2(BUFFER_SIZE);
   localparam int CW = PW + 1;

   flit_t            mem_q [BUFFER_SIZE];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   flit_t            data_q, data_d;
   flit_t            head;

   assign is_full_o    = (count_q == CW'(BUFFER_SIZE));
   assign is_empty_o   = (count_q == '0);
   assign count_o      = count_q;
   assign head         = mem_q[rd_ptr_q];
   assign head_label_o = head.flit_label;
   assign data_o       = data_q;

   assign rd_acc_o = read_i && !is_empty_o;
   // A pop in the same cycle frees a slot, so a full buffer still takes the write.
   assign wr_acc_o = write_i && (!is_full_o || rd_acc_o);

   always_comb begin
      count_d = count_q;
      case ({wr_acc_o, rd_acc_o})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      data_d       = head;
      data_d.vc_id = vc_i;
   end

   always_ff @(posedge clk) begin
      if (wr_acc_o) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         data_q   <= '0;
      end else begin
         count_q <= count_d;
         if (wr_acc_o) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_acc_o) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            data_q   <= data_d;
         end
      end
   end

endmodule

// File: rtl/noc_input_buffer.sv
// noc_input_buffer: one VC input FIFO of a router input port with packet tracking.
// Ports: clk, rst (async, active-low); data_i/write_i incoming flits; read_i pop;
// out_port_i route of the head flit being written; vc_valid_i/vc_new_i downstream VC
// grant; data_o last popped flit carrying the allocated VC; is_full_o/is_empty_o
// occupancy; out_port_o route of the current packet; on_off_o upstream may send.
//
// state     | meaning
// IB_IDLE   | no packet open; only HEAD/HEADTAIL writes are accepted
// IB_VA     | head stored, waiting for downstream VC grant; reads ignored
// IB_ACTIVE | VC granted; flits drain until a TAIL/HEADTAIL is read
module noc_input_buffer
   import noc_params::*;
#(
   parameter int BUFFER_SIZE    = 8,
   parameter int PIPELINE_DEPTH = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  flit_t              data_i,
   input  logic               write_i,
   input  logic               read_i,
   input  port_t              out_port_i,
   input  logic               vc_valid_i,
   input  logic [VC_SIZE-1:0] vc_new_i,
   output flit_t              data_o,
   output logic               is_full_o,
   output logic               is_empty_o,
   output port_t              out_port_o,
   output logic               on_off_o
);

   ib_state_t                    state_q, state_d;
   port_t                        out_port_q, out_port_d;
   logic [VC_SIZE-1:0]           vc_q, vc_d;
   logic                         wr_req, rd_req, wr_acc, rd_acc;
   flit_label_t                  head_label;
   logic [$clog2(BUFFER_SIZE):0] count_w;

   // Non-head flits arriving with no open packet are orphans and are dropped.
   assign wr_req = write_i && !((state_q == IB_IDLE) && !is_head(data_i.flit_label));
   assign rd_req = read_i && (state_q == IB_ACTIVE);

   circular_buffer #(.BUFFER_SIZE(BUFFER_SIZE)) u_buf (
      .clk          (clk),
      .rst          (rst),
      .data_i       (data_i),
      .write_i      (wr_req),
      .read_i       (rd_req),
      .vc_i         (vc_q),
      .data_o       (data_o),
      .head_label_o (head_label),
      .wr_acc_o     (wr_acc),
      .rd_acc_o     (rd_acc),
      .is_full_o    (is_full_o),
      .is_empty_o   (is_empty_o),
      .count_o      (count_w)
   );

   always_comb begin
      state_d    = state_q;
      out_port_d = out_port_q;
      vc_d       = vc_q;
      case (state_q)
         IB_IDLE: begin
            if (wr_acc && is_head(data_i.flit_label)) begin
               out_port_d = out_port_i;
               state_d    = IB_VA;
            end
         end
         IB_VA: begin
            if (vc_valid_i) begin
               vc_d    = vc_new_i;
               state_d = IB_ACTIVE;
            end
         end
         IB_ACTIVE: begin
            if (rd_acc && is_tail(head_label)) state_d = IB_IDLE;
         end
         default: state_d = IB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IB_IDLE;
         out_port_q <= LOCAL;
         vc_q       <= '0;
      end else begin
         state_q    <= state_d;
         out_port_q <= out_port_d;
         vc_q       <= vc_d;
      end
   end

   assign out_port_o = out_port_q;
   // Upstream keeps sending only while free slots exceed the flits it may have in flight.
   assign on_off_o   = (BUFFER_SIZE - int'(count_w)) > PIPELINE_DEPTH;

endmodule

// File: tb/tb_noc_input_buffer.sv
module tb_noc_input_buffer;
   import noc_params::*;

   logic               clk = 1'b0;
   logic               rst;
   flit_t              data_i, data_o;
   logic               write_i, read_i, vc_valid_i;
   port_t              out_port_i, out_port_o;
   logic [VC_SIZE-1:0] vc_new_i;
   logic               is_full_o, is_empty_o, on_off_o;

   always #5 clk = ~clk;

   noc_input_buffer #(.BUFFER_SIZE(8), .PIPELINE_DEPTH(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .data_i     (data_i),
      .write_i    (write_i),
      .read_i     (read_i),
      .out_port_i (out_port_i),
      .vc_valid_i (vc_valid_i),
      .vc_new_i   (vc_new_i),
      .data_o     (data_o),
      .is_full_o  (is_full_o),
      .is_empty_o (is_empty_o),
      .out_port_o (out_port_o),
      .on_off_o   (on_off_o)
   );

   int    n_tests = 0;
   int    n_fail  = 0;
   flit_t sb_q [$];
   flit_t last_exp;

   typedef struct {
      bit                        wr;
      flit_label_t               lbl;
      logic [VC_SIZE-1:0]        vc;
      logic [FLIT_DATA_SIZE-1:0] pl;
      bit                        push;
      bit                        rd;
      bit                        pop;
      logic [VC_SIZE-1:0]        evc;
      port_t                     port;
      bit                        vv;
      logic [VC_SIZE-1:0]        vn;
      bit                        e_empty;
      bit                        e_full;
      bit                        e_on;
      port_t                     e_port;
   } vec_t;

   vec_t vq [$];

   function automatic flit_t mk(flit_label_t l, logic [VC_SIZE-1:0] v,
                                logic [FLIT_DATA_SIZE-1:0] pl);
      flit_t f;
      f.flit_label = l;
      f.vc_id      = v;
      f.data.bt_pl = pl;
      return f;
   endfunction

   task automatic chk_bit(input string nm, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chk_port(input string nm, input port_t act, input port_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_flit(input string nm, input flit_t act, input flit_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_flags(input string nm, input bit e_empty, input bit e_full,
                            input bit e_on, input port_t e_port);
      chk_bit({nm, ".is_empty_o"}, is_empty_o, e_empty);
      chk_bit({nm, ".is_full_o"}, is_full_o, e_full);
      chk_bit({nm, ".on_off_o"}, on_off_o, e_on);
      chk_port({nm, ".out_port_o"}, out_port_o, e_port);
   endtask

   // One clock: drive at negedge, sample 1 ns after the rising edge. A pushed flit
   // enters the scoreboard; a pop takes the oldest one and stamps the expected VC.
   task automatic cyc(input string nm, input bit wr, input flit_t f, input bit push,
                      input bit rd, input bit pop, input logic [VC_SIZE-1:0] evc,
                      input port_t p, input bit vv, input logic [VC_SIZE-1:0] vn);
      @(negedge clk);
      write_i    = wr;
      data_i     = f;
      read_i     = rd;
      out_port_i = p;
      vc_valid_i = vv;
      vc_new_i   = vn;
      if (push) sb_q.push_back(f);
      @(posedge clk);
      #1;
      write_i    = 1'b0;
      read_i     = 1'b0;
      vc_valid_i = 1'b0;
      if (pop) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.scoreboard: got pop expected none", nm);
         end else begin
            last_exp       = sb_q.pop_front();
            last_exp.vc_id = evc;
         end
      end
      chk_flit({nm, ".data_o"}, data_o, last_exp);
   endtask

   task automatic addv(input bit wr, input flit_label_t lbl, input logic [VC_SIZE-1:0] vc,
                       input logic [FLIT_DATA_SIZE-1:0] pl, input bit push, input bit rd,
                       input bit pop, input logic [VC_SIZE-1:0] evc, input port_t port,
                       input bit vv, input logic [VC_SIZE-1:0] vn, input bit e_empty,
                       input bit e_full, input bit e_on, input port_t e_port);
      vec_t v;
      v.wr = wr; v.lbl = lbl; v.vc = vc; v.pl = pl; v.push = push;
      v.rd = rd; v.pop = pop; v.evc = evc; v.port = port; v.vv = vv; v.vn = vn;
      v.e_empty = e_empty; v.e_full = e_full; v.e_on = e_on; v.e_port = e_port;
      vq.push_back(v);
   endtask

   initial begin
      int c;
      flit_label_t l;

      rst        = 1'b0;
      data_i     = '0;
      write_i    = 1'b0;
      read_i     = 1'b0;
      out_port_i = LOCAL;
      vc_valid_i = 1'b0;
      vc_new_i   = '0;
      last_exp   = '0;
      #22;
      chk_flags("reset", 1'b1, 1'b0, 1'b1, LOCAL);
      chk_flit("reset.data_o", data_o, '0);
      @(negedge clk);
      rst = 1'b1;

      // Packet 1: route NORTH, flits on VC 0, downstream VC 1.
      addv(1, HEAD, 0, 16'hA001, 1, 0, 0, 0, NORTH, 0, 0, 0, 0, 1, NORTH);
      addv(1, BODY, 0, 16'hA002, 1, 0, 0, 0, SOUTH, 1, 1, 0, 0, 1, NORTH);
      addv(0, BODY, 0, 16'h0000, 0, 1, 1, 1, LOCAL, 0, 0, 0, 0, 1, NORTH);
      addv(0, BODY, 0, 16'h0000, 0, 1, 1, 1, LOCAL, 0, 0, 1, 0, 1, NORTH);
      addv(1, BODY, 0, 16'hA003, 1, 0, 0, 0, EAST,  0, 0, 0, 0, 1, NORTH);
      addv(1, TAIL, 0, 16'hA004, 1, 0, 0, 0, EAST,  0, 0, 0, 0, 1, NORTH);
      addv(0, BODY, 0, 16'h0000, 0, 1, 1, 1, LOCAL, 0, 0, 0, 0, 1, NORTH);
      addv(0, BODY, 0, 16'h0000, 0, 1, 1, 1, LOCAL, 0, 0, 1, 0, 1, NORTH);
      // Packet 2: route WEST, flits on VC 1, downstream VC 0.
      addv(1, HEAD, 1, 16'hB001, 1, 0, 0, 0, WEST,  0, 0, 0, 0, 1, WEST);
      addv(1, BODY, 1, 16'hB002, 1, 0, 0, 0, NORTH, 1, 0, 0, 0, 1, WEST);
      addv(0, BODY, 0, 16'h0000, 0, 1, 1, 0, LOCAL, 0, 0, 0, 0, 1, WEST);
      addv(0, BODY, 0, 16'h0000, 0, 1, 1, 0, LOCAL, 0, 0, 1, 0, 1, WEST);
      addv(1, BODY, 1, 16'hB003, 1, 0, 0, 0, SOUTH, 0, 0, 0, 0, 1, WEST);
      addv(1, TAIL, 1, 16'hB004, 1, 0, 0, 0, SOUTH, 0, 0, 0, 0, 1, WEST);
      addv(0, BODY, 0, 16'h0000, 0, 1, 1, 0, LOCAL, 0, 0, 0, 0, 1, WEST);
      addv(0, BODY, 0, 16'h0000, 0, 1, 1, 0, LOCAL, 0, 0, 1, 0, 1, WEST);
      // Back in IDLE: orphan BODY/TAIL dropped, read of empty buffer ignored.
      addv(1, BODY, 0, 16'hB0FF, 0, 0, 0, 0, NORTH, 0, 0, 1, 0, 1, WEST);
      addv(0, BODY, 0, 16'h0000, 0, 1, 0, 0, LOCAL, 0, 0, 1, 0, 1, WEST);
      addv(1, TAIL, 0, 16'hB0FE, 0, 0, 0, 0, NORTH, 0, 0, 1, 0, 1, WEST);

      for (int i = 0; i < vq.size(); i++) begin
         string nm;
         nm = $sformatf("vec%0d", i);
         cyc(nm, vq[i].wr, mk(vq[i].lbl, vq[i].vc, vq[i].pl), vq[i].push, vq[i].rd,
             vq[i].pop, vq[i].evc, vq[i].port, vq[i].vv, vq[i].vn);
         chk_flags(nm, vq[i].e_empty, vq[i].e_full, vq[i].e_on, vq[i].e_port);
      end

      // Fill to 8; a HEAD written mid-packet must not change the latched route.
      cyc("fill0", 1, mk(HEAD, 0, 16'hC000), 1, 0, 0, 0, SOUTH, 0, 0);
      chk_flags("fill0", 0, 0, 1, SOUTH);
      for (int k = 1; k < 8; k++) begin
         l = (k == 1) ? HEAD : ((k == 7) ? TAIL : BODY);
         c = k + 1;
         cyc($sformatf("fill%0d", k), 1, mk(l, 0, 16'hC000 + 16'(k)), 1, 0, 0, 0,
             EAST, (k == 1), 1);
         chk_flags($sformatf("fill%0d", k), 0, (c == 8), ((8 - c) > 5), SOUTH);
      end
      cyc("fill_over", 1, mk(BODY, 0, 16'hC0FF), 0, 0, 0, 0, EAST, 0, 0);
      chk_flags("fill_over", 0, 1, 0, SOUTH);
      for (int k = 0; k < 8; k++) begin
         c = 7 - k;
         cyc($sformatf("drain%0d", k), 0, '0, 0, 1, 1, 1, LOCAL, 0, 0);
         chk_flags($sformatf("drain%0d", k), (c == 0), 0, ((8 - c) > 5), SOUTH);
      end

      // Read while waiting for VC grant is ignored; then simultaneous read+write at 4.
      cyc("va_head", 1, mk(HEAD, 1, 16'hD000), 1, 0, 0, 0, EAST, 0, 0);
      chk_flags("va_head", 0, 0, 1, EAST);
      cyc("va_read", 0, '0, 0, 1, 0, 0, LOCAL, 0, 0);
      chk_flags("va_read", 0, 0, 1, EAST);
      cyc("va_b1", 1, mk(BODY, 1, 16'hD001), 1, 0, 0, 0, LOCAL, 1, 0);
      chk_flags("va_b1", 0, 0, 1, EAST);
      cyc("va_b2", 1, mk(BODY, 1, 16'hD002), 1, 0, 0, 0, LOCAL, 0, 0);
      chk_flags("va_b2", 0, 0, 0, EAST);
      cyc("va_b3", 1, mk(BODY, 1, 16'hD003), 1, 0, 0, 0, LOCAL, 0, 0);
      chk_flags("va_b3", 0, 0, 0, EAST);
      cyc("rw4", 1, mk(TAIL, 1, 16'hD004), 1, 1, 1, 0, LOCAL, 0, 0);
      chk_flags("rw4", 0, 0, 0, EAST);
      for (int k = 0; k < 4; k++) begin
         c = 3 - k;
         cyc($sformatf("rw_drain%0d", k), 0, '0, 0, 1, 1, 0, LOCAL, 0, 0);
         chk_flags($sformatf("rw_drain%0d", k), (c == 0), 0, ((8 - c) > 5), EAST);
      end
      cyc("rw_idle", 1, mk(BODY, 0, 16'hD0FF), 0, 0, 0, 0, LOCAL, 0, 0);
      chk_flags("rw_idle", 1, 0, 1, EAST);

      // Asynchronous reset in the middle of a packet.
      cyc("mid_head", 1, mk(HEAD, 0, 16'hE001), 1, 0, 0, 0, NORTH, 0, 0);
      cyc("mid_body", 1, mk(BODY, 0, 16'hE002), 1, 0, 0, 0, LOCAL, 1, 1);
      cyc("mid_read", 0, '0, 0, 1, 1, 1, LOCAL, 0, 0);
      #2;
      rst = 1'b0;
      #1;
      chk_flags("mid_rst", 1, 0, 1, LOCAL);
      chk_flit("mid_rst.data_o", data_o, '0);
      @(negedge clk);
      rst = 1'b1;
      sb_q.delete();
      last_exp = '0;
      cyc("post_rst_rd", 0, '0, 0, 1, 0, 0, LOCAL, 0, 0);
      chk_flags("post_rst_rd", 1, 0, 1, LOCAL);
      cyc("post_rst_body", 1, mk(BODY, 0, 16'hE0FF), 0, 0, 0, 0, NORTH, 0, 0);
      chk_flags("post_rst_body", 1, 0, 1, LOCAL);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
